// File: rtl/ram_sp32x8_if.sv
// Bus bundle for the single-port scratch RAM: one shared address, a write strobe,
// write data, and registered read data.
interface ram_sp32x8_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
);
  logic [DATA_WIDTH-1:0] d_in;
  logic [ADDR_WIDTH-1:0] address;
  logic                  w;
  logic [DATA_WIDTH-1:0] out;

  modport master (
    output d_in,
    output address,
    output w,
    input  out
  );

  modport slave (
    input  d_in,
    input  address,
    input  w,
    output out
  );
endinterface

// File: rtl/ram_sp32x8.sv
// Single-port RAM in flops, cleared by async reset; read data is registered (1 cycle).
// No backpressure: one access per clock, and write cycles leave the output register untouched.
module ram_sp32x8 #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  ram_sp32x8_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] out_q;
  logic [DATA_WIDTH-1:0] out_d;

  // The per-word compare skips the access when address or w is unknown, so a bad
  // cycle never lands on some other word.
  always_comb begin
    mem_d = mem_q;
    out_d = out_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.address == ADDR_WIDTH'(i)) begin
        if (bus.w == 1'b1) begin
          mem_d[i] = bus.d_in;
        end else if (bus.w == 1'b0) begin
          out_d = mem_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      out_q <= '0;
    end else begin
      mem_q <= mem_d;
      out_q <= out_d;
    end
  end

  assign bus.out = out_q;

endmodule

// File: tb/tb_ram_sp32x8.sv
// Directed plus randomized checks of ram_sp32x8 against an array reference model.
module tb_ram_sp32x8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  logic [7:0] model [32];
  logic [7:0] exp_out;

  ram_sp32x8_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) bus ();

  ram_sp32x8 #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 8'h00;
    exp_out = 8'h00;
  endtask

  // Called just after a negedge: apply inputs, take one rising edge, check at the next negedge.
  task automatic op(input string tag, input logic wv, input logic [4:0] a, input logic [7:0] d);
    bus.w       = wv;
    bus.address = a;
    bus.d_in    = d;
    @(posedge clk);
    if (rst_n) begin
      if (wv) model[a] = d;
      else    exp_out  = model[a];
    end
    @(negedge clk);
    chk(tag, bus.out, exp_out);
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 32; i++) op(tag, 1'b0, 5'(i), 8'h00);
  endtask

  initial begin
    logic       wv;
    logic [4:0] a;
    logic [7:0] d;

    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    bus.w       = 1'b0;
    bus.address = '0;
    bus.d_in    = '0;
    model_clear();

    // Power-up
    #1;
    chk("reset_out", bus.out, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_release_out", bus.out, 8'h00);
    op("read5_after_reset", 1'b0, 5'd5, 8'h00);

    // Write then readback; out holds across write cycles
    op("wr0_hold",  1'b1, 5'd0, 8'h10);
    op("wr2_hold",  1'b1, 5'd2, 8'h11);
    op("wr7_hold",  1'b1, 5'd7, 8'hAF);
    op("rd0",       1'b0, 5'd0, 8'h00);
    op("rd2",       1'b0, 5'd2, 8'h00);
    op("rd7",       1'b0, 5'd7, 8'h00);

    // Address/w wiggle between edges must not reach out
    for (int i = 0; i < 4; i++) begin
      bus.address = 5'(i * 9);
      bus.w       = 1'(i % 2);
      #1;
      chk("hold_between_edges", bus.out, exp_out);
    end
    @(negedge clk);

    // Boundaries
    op("wr31", 1'b1, 5'd31, 8'h5A);
    op("wr0b", 1'b1, 5'd0,  8'hA5);
    op("rd31", 1'b0, 5'd31, 8'h00);
    op("rd0b", 1'b0, 5'd0,  8'h00);
    op("rd1",  1'b0, 5'd1,  8'h00);

    // Back-to-back and overwrite
    op("wr4",   1'b1, 5'd4, 8'h33);
    op("rd4",   1'b0, 5'd4, 8'h00);
    op("ovw4",  1'b1, 5'd4, 8'hCC);
    op("rd4b",  1'b0, 5'd4, 8'h00);

    // Async reset mid-run with out = 0xAF
    op("rd7_pre_reset", 1'b0, 5'd7, 8'h00);
    chk("out_is_af", exp_out, bus.out);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("async_reset_out", bus.out, 8'h00);
    op("write_ignored_in_reset", 1'b1, 5'd9, 8'h77);
    rst_n = 1'b1;
    op("rd7_after_reset", 1'b0, 5'd7, 8'h00);
    sweep("sweep_after_reset");

    // Randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("rand_async_reset", bus.out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
      end
      wv = 1'($urandom_range(0, 1));
      a  = 5'($urandom_range(0, 31));
      d  = 8'($urandom);
      op("rand_op", wv, a, d);
    end
    sweep("final_sweep");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
